l1_refill_controller: RTL and testbench

Miss handler for the direct-mapped L1 instruction cache (16 lines × 64 bits, 25-bit tag, 4-bit index, 3-bit offset). On a fetch miss it stalls the fetch stage and reads the 8-byte line from the memory side as two 32-bit beats over a valid/ready request channel and a valid-only response channel. It then drives the cache's write port (`writeCache`, `writeIndex`, `writeTag`, `writeData`) for exactly one cycle.

---
 rtl/l1_refill_controller.sv | 114 +++++++++++
 tb/tb_l1_refill_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_refill_controller.sv
// L1 instruction-cache miss handler: fetches an 8-byte line as two 32-bit beats and fills it.
// Optional build macro REFILL_CRITICAL_WORD_FIRST_EN requests the word being fetched first.
module l1_refill_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetchValid,
  input  logic [31:0] pcAddress,
  input  logic        cacheHit,
  output logic        stall,
  output logic        memReqValid,
  input  logic        memReqReady,
  output logic [31:0] memReqAddress,
  input  logic        memRespValid,
  input  logic [31:0] memRespData,
  output logic        writeCache,
  output logic [3:0]  writeIndex,
  output logic [24:0] writeTag,
  output logic [63:0] writeData
);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    FILL
  } state_t;

  state_t      state;
  logic [28:0] lineAddr;
  logic        firstSel;
  logic [31:0] wordLo;
  logic [31:0] wordHi;
  logic        missFirstSel;
  logic        unusedPcBits;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  assign missFirstSel = pcAddress[2];
`else
  assign missFirstSel = 1'b0;
`endif

  // The byte offset never reaches the memory side; requests are word aligned.
  assign unusedPcBits = ^pcAddress[2:0];

  assign stall      = (state != IDLE) | (fetchValid & ~cacheHit);
  assign writeIndex = lineAddr[3:0];
  assign writeTag   = lineAddr[28:4];
  assign writeData  = {wordHi, wordLo};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lineAddr      <= '0;
      firstSel      <= 1'b0;
      wordLo        <= '0;
      wordHi        <= '0;
      memReqValid   <= 1'b0;
      memReqAddress <= '0;
      writeCache    <= 1'b0;
    end else begin
      writeCache <= 1'b0;
      case (state)
        IDLE: begin
          if (fetchValid && !cacheHit) begin
            lineAddr      <= pcAddress[31:3];
            firstSel      <= missFirstSel;
            memReqValid   <= 1'b1;
            memReqAddress <= {pcAddress[31:3], missFirstSel, 2'b00};
            state         <= REQ0;
          end
        end
        REQ0: begin
          if (memReqReady) begin
            memReqValid <= 1'b0;
            state       <= WAIT0;
          end
        end
        WAIT0: begin
          // Responses arriving in any other state are dropped.
          if (memRespValid) begin
            if (firstSel) wordHi <= memRespData;
            else          wordLo <= memRespData;
            memReqValid   <= 1'b1;
            memReqAddress <= {lineAddr, ~firstSel, 2'b00};
            state         <= REQ1;
          end
        end
        REQ1: begin
          if (memReqReady) begin
            memReqValid <= 1'b0;
            state       <= WAIT1;
          end
        end
        WAIT1: begin
          if (memRespValid) begin
            if (firstSel) wordLo <= memRespData;
            else          wordHi <= memRespData;
            writeCache <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_refill_controller.sv
// Self-checking bench for l1_refill_controller: a small memory model answers requests, and
// expected request addresses and fill records are queued as each miss is launched.
module tb_l1_refill_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchValid;
  logic [31:0] pcAddress;
  logic        cacheHit;
  logic        stall;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memReqAddress;
  logic        memRespValid;
  logic [31:0] memRespData;
  logic        writeCache;
  logic [3:0]  writeIndex;
  logic [24:0] writeTag;
  logic [63:0] writeData;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] reqQ[$];
  logic [92:0] fillQ[$];

  always #5 clk = ~clk;

  l1_refill_controller dut (
    .clk(clk),
    .reset(reset),
    .fetchValid(fetchValid),
    .pcAddress(pcAddress),
    .cacheHit(cacheHit),
    .stall(stall),
    .memReqValid(memReqValid),
    .memReqReady(memReqReady),
    .memReqAddress(memReqAddress),
    .memRespValid(memRespValid),
    .memRespData(memRespData),
    .writeCache(writeCache),
    .writeIndex(writeIndex),
    .writeTag(writeTag),
    .writeData(writeData)
  );

  // Memory contents: the two scenario words, a derived pattern everywhere else.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_1230) return 32'hAAAA_0000;
    if (a == 32'h0000_1234) return 32'hBBBB_1111;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Runs one miss cycle by cycle; cycle 0 is the cycle the miss is first presented.
  task automatic runMiss(input logic [31:0] pc, input int readyDelay, input int respLat,
                         input bit spurious, input bit abortInWait1, input string name);
    logic [28:0] line;
    logic        sel;
    logic [31:0] respAddr;
    logic [92:0] expRec;
    int          expFill;
    int          waitCnt;
    int          respCnt;
    bit          respPending;
    bit          fillSeen;
    bit          done;
    bit          aborting;
    line = pc[31:3];
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    sel = pc[2];
`else
    sel = 1'b0;
`endif
    reqQ.push_back({line, sel, 2'b00});
    reqQ.push_back({line, ~sel, 2'b00});
    fillQ.push_back({line[3:0], line[28:4], memWord({line, 1'b1, 2'b00}), memWord({line, 1'b0, 2'b00})});
    expFill     = 5 + 2 * readyDelay + 2 * (respLat - 1);
    waitCnt     = 0;
    respCnt     = 0;
    respPending = 1'b0;
    fillSeen    = 1'b0;
    done        = 1'b0;
    aborting    = 1'b0;
    respAddr    = '0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      fetchValid   = 1'b1;
      pcAddress    = pc;
      cacheHit     = fillSeen;
      memRespValid = 1'b0;
      memRespData  = 32'h0;
      memReqReady  = 1'b0;
      if (respPending) begin
        respCnt++;
        if (respCnt == respLat) begin
          memRespValid = 1'b1;
          memRespData  = memWord(respAddr);
          respPending  = 1'b0;
        end
      end
      if (abortInWait1 && memRespValid && reqQ.size() == 0) begin
        memRespValid = 1'b0;
        reset        = 1'b1;
        aborting     = 1'b1;
      end
      if (memReqValid && !aborting) begin
        compared++;
        if (reqQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL %s unexpected request: got %h, expected no request", name, memReqAddress);
        end else if (memReqAddress !== reqQ[0]) begin
          mismatched++;
          $display("[TB] FAIL %s request address cycle %0d: got %h expected %h", name, cyc, memReqAddress, reqQ[0]);
        end
        if (spurious && reqQ.size() == 2 && waitCnt == 0) begin
          memRespValid = 1'b1;
          memRespData  = 32'hDEAD_BEEF;
        end
        memReqReady = (waitCnt >= readyDelay);
      end
      #1;
      if (aborting) begin
        done = 1'b1;
      end else begin
        if (!fillSeen) begin
          compared++;
          if (stall !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s stall during refill cycle %0d: got %b expected 1", name, cyc, stall);
          end
        end
        if (writeCache === 1'b1) begin
          expRec = fillQ.pop_front();
          compared++;
          if ({writeIndex, writeTag, writeData} !== expRec || cyc != expFill) begin
            mismatched++;
            $display("[TB] FAIL %s fill: got cycle %0d idx %h tag %h data %h expected cycle %0d idx %h tag %h data %h",
                     name, cyc, writeIndex, writeTag, writeData, expFill, expRec[92:89], expRec[88:64], expRec[63:0]);
          end
          fillSeen = 1'b1;
        end else if (fillSeen) begin
          compared++;
          if (stall !== 1'b0 || memReqValid !== 1'b0 || cyc != expFill + 1) begin
            mismatched++;
            $display("[TB] FAIL %s release: got cycle %0d stall %b reqValid %b expected cycle %0d stall 0 reqValid 0",
                     name, cyc, stall, memReqValid, expFill + 1);
          end
          done = 1'b1;
        end
        if (memReqValid && memReqReady) begin
          respAddr    = memReqAddress;
          respPending = 1'b1;
          respCnt     = 0;
          waitCnt     = 0;
          if (reqQ.size() != 0) void'(reqQ.pop_front());
        end else if (memReqValid) begin
          waitCnt++;
        end
      end
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: got no completion within 80 cycles, expected fill at cycle %0d", name, expFill);
      reqQ.delete();
      fillQ.delete();
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    fetchValid   = 1'b0;
    pcAddress    = 32'h0;
    cacheHit     = 1'b0;
    memReqReady  = 1'b0;
    memRespValid = 1'b0;
    memRespData  = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if ({stall, memReqValid, memReqAddress, writeCache, writeIndex, writeTag, writeData} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset outputs: got stall %b rv %b ra %h wc %b idx %h tag %h data %h expected all zero",
               stall, memReqValid, memReqAddress, writeCache, writeIndex, writeTag, writeData);
    end
    fetchValid = 1'b1;
    #1;
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset stall equation: got %b expected 1", stall);
    end
    fetchValid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_hit();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fetchValid = 1'b1;
      cacheHit   = 1'b1;
      pcAddress  = 32'h0000_4000 + 32'(i * 4);
      #1;
      compared++;
      if ({stall, memReqValid, writeCache} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL hit cycle %0d: got stall/reqValid/writeCache %b expected 000", i, {stall, memReqValid, writeCache});
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    runMiss(32'h0000_2468, 0, 1, 1'b0, 1'b1, "abort");
    @(negedge clk);
    reset      = 1'b0;
    fetchValid = 1'b0;
    cacheHit   = 1'b0;
    #1;
    compared++;
    if ({stall, memReqValid, memReqAddress, writeCache, writeIndex, writeTag, writeData} !== '0) begin
      mismatched++;
      $display("[TB] FAIL abort outputs: got stall %b rv %b ra %h wc %b idx %h tag %h data %h expected all zero",
               stall, memReqValid, memReqAddress, writeCache, writeIndex, writeTag, writeData);
    end
    void'(fillQ.pop_front());
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      memRespValid = (i == 0);
      memRespData  = 32'h1357_9BDF;
      #1;
      compared++;
      if (writeCache !== 1'b0 || memReqValid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL abort quiet cycle %0d: got writeCache %b reqValid %b expected 0 0", i, writeCache, memReqValid);
      end
    end
    memRespValid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcA;
    logic [31:0] pcB;
    pcA = $urandom & 32'hFFFF_FFFC;
    pcB = pcA ^ 32'h0001_0088;
    runMiss(pcA, 1, 1, 1'b0, 1'b0, "b2b_first");
    runMiss(pcB, 0, 2, 1'b0, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_hit();
    runMiss(32'h0000_1234, 0, 1, 1'b0, 1'b0, "basic");
    runMiss(32'h0000_1234, 3, 1, 1'b0, 1'b0, "backpressure");
    runMiss(32'h0000_1230, 2, 1, 1'b1, 1'b0, "spurious");
    runMiss(32'h0ABC_DEF4, 0, 3, 1'b0, 1'b0, "latency");
    test_reset_mid_refill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
